// File: rtl/ip_rgb2yuv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ip_rgb2yuv_seq
//  Purpose  : Resource-shared RGB -> YCbCr (8-bit) converter. One three-term
//             constant-coefficient MAC is time-multiplexed over the Y, Cb and
//             Cr terms by a small FSM, yielding one pixel every 4 cycles.
//  Ports    : clk, rst                     - clock, synchronous active-high reset
//             i_vld / o_rdy                - upstream handshake
//             i_data_r/_g/_b [DAT_SZ]      - unsigned RGB pixel
//             i_byp                        - bypass select (IP_RGB2YUV_BYPASS_EN only)
//             o_vld / i_rdy                - downstream handshake
//             o_data_y/_cb/_cr [8]         - YCbCr result
//             o_busy                       - FSM not idle
//  Options  : IP_RGB2YUV_BYPASS_EN - adds i_byp; when set with a pixel the MSBs
//             of R/G/B are passed through as Y/Cb/Cr with unchanged timing.
//  Revision : 1.0 - initial release
// ============================================================================
module ip_rgb2yuv_seq #(
    parameter int DAT_SZ = 10,
    parameter int ACC_SZ = DAT_SZ + 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    output logic              o_rdy,
    input  logic [DAT_SZ-1:0] i_data_r,
    input  logic [DAT_SZ-1:0] i_data_g,
    input  logic [DAT_SZ-1:0] i_data_b,
`ifdef IP_RGB2YUV_BYPASS_EN
    input  logic              i_byp,
`endif
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [7:0]        o_data_y,
    output logic [7:0]        o_data_cb,
    output logic [7:0]        o_data_cr,
    output logic              o_busy
);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_s_y  = 3'd1;
    localparam logic [2:0] c_s_cb = 3'd2;
    localparam logic [2:0] c_s_cr = 3'd3;
    localparam logic [2:0] c_s_out = 3'd4;

    // Rounding constant: coefficients are /256 and the input is DAT_SZ wide,
    // so the combined scale is 2^DAT_SZ.
    localparam logic signed [ACC_SZ-1:0] c_half   = ACC_SZ'(2 ** (DAT_SZ - 1));
    localparam logic signed [ACC_SZ-1:0] c_uv_ofs = ACC_SZ'(128);
    localparam logic signed [ACC_SZ-1:0] c_max    = ACC_SZ'(255);

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic                    w_accept;

    logic [DAT_SZ-1:0]       r_r;
    logic [DAT_SZ-1:0]       r_g;
    logic [DAT_SZ-1:0]       r_b;
    logic [7:0]              r_y;
    logic [7:0]              r_cb;

    logic signed [ACC_SZ-1:0] w_k_r;
    logic signed [ACC_SZ-1:0] w_k_g;
    logic signed [ACC_SZ-1:0] w_k_b;
    logic signed [ACC_SZ-1:0] w_ext_r;
    logic signed [ACC_SZ-1:0] w_ext_g;
    logic signed [ACC_SZ-1:0] w_ext_b;
    logic signed [ACC_SZ-1:0] w_sum;
    logic signed [ACC_SZ-1:0] w_rnd;
    logic signed [ACC_SZ-1:0] w_off;
    logic [7:0]               w_mac8;
    logic [7:0]               w_res;

`ifdef IP_RGB2YUV_BYPASS_EN
    logic                    r_byp;
`endif

    // ------------------------------------------------------------------
    // Handshake and FSM
    // ------------------------------------------------------------------
    assign o_rdy    = (r_state == c_idle) | ((r_state == c_s_out) & i_rdy);
    assign w_accept = i_vld & o_rdy;
    assign o_vld    = (r_state == c_s_out);
    assign o_busy   = (r_state != c_idle);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_state_nxt = c_s_y;
            c_s_y:   w_state_nxt = c_s_cb;
            c_s_cb:  w_state_nxt = c_s_cr;
            c_s_cr:  w_state_nxt = c_s_out;
            c_s_out: if (i_rdy) w_state_nxt = i_vld ? c_s_y : c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared MAC: coefficient set follows the state
    // ------------------------------------------------------------------
    always_comb begin
        w_k_r = ACC_SZ'(127);
        w_k_g = ACC_SZ'(-106);
        w_k_b = ACC_SZ'(-21);
        case (r_state)
            c_s_y: begin
                w_k_r = ACC_SZ'(77);
                w_k_g = ACC_SZ'(150);
                w_k_b = ACC_SZ'(29);
            end
            c_s_cb: begin
                w_k_r = ACC_SZ'(-43);
                w_k_g = ACC_SZ'(-84);
                w_k_b = ACC_SZ'(127);
            end
            default: ;
        endcase
    end

    assign w_ext_r = signed'({{(ACC_SZ - DAT_SZ){1'b0}}, r_r});
    assign w_ext_g = signed'({{(ACC_SZ - DAT_SZ){1'b0}}, r_g});
    assign w_ext_b = signed'({{(ACC_SZ - DAT_SZ){1'b0}}, r_b});

    assign w_sum = w_k_r * w_ext_r + w_k_g * w_ext_g + w_k_b * w_ext_b;
    assign w_rnd = (w_sum + c_half) >>> DAT_SZ;
    assign w_off = w_rnd + ((r_state == c_s_y) ? '0 : c_uv_ofs);

    always_comb begin
        w_mac8 = w_off[7:0];
        if (w_off[ACC_SZ-1]) begin
            w_mac8 = 8'h00;
        end else if (w_off > c_max) begin
            w_mac8 = 8'hFF;
        end
    end

`ifdef IP_RGB2YUV_BYPASS_EN
    always_comb begin
        w_res = w_mac8;
        if (r_byp) begin
            case (r_state)
                c_s_y:   w_res = r_r[DAT_SZ-1 -: 8];
                c_s_cb:  w_res = r_g[DAT_SZ-1 -: 8];
                default: w_res = r_b[DAT_SZ-1 -: 8];
            endcase
        end
    end
`else
    assign w_res = w_mac8;
`endif

    // ------------------------------------------------------------------
    // Datapath registers. Y and Cb are staged internally so the three
    // outputs change together on the S_CR -> S_OUT edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_y       <= '0;
            r_cb      <= '0;
            o_data_y  <= '0;
            o_data_cb <= '0;
            o_data_cr <= '0;
        end else begin
            if (w_accept) begin
                r_r <= i_data_r;
                r_g <= i_data_g;
                r_b <= i_data_b;
            end
            case (r_state)
                c_s_y:  r_y  <= w_res;
                c_s_cb: r_cb <= w_res;
                c_s_cr: begin
                    o_data_y  <= r_y;
                    o_data_cb <= r_cb;
                    o_data_cr <= w_res;
                end
                default: ;
            endcase
        end
    end

`ifdef IP_RGB2YUV_BYPASS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp <= 1'b0;
        end else if (w_accept) begin
            r_byp <= i_byp;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ip_rgb2yuv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ip_rgb2yuv_seq
//  Purpose  : Self-checking bench for ip_rgb2yuv_seq. Expected results are
//             pushed to a scoreboard on each accepted pixel and compared when
//             the DUT hands a result downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ip_rgb2yuv_seq;

    localparam int DAT_SZ = 10;
    localparam int ACC_SZ = DAT_SZ + 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_vld = 1'b0;
    logic              o_rdy;
    logic [DAT_SZ-1:0] i_data_r = '0;
    logic [DAT_SZ-1:0] i_data_g = '0;
    logic [DAT_SZ-1:0] i_data_b = '0;
    logic              tb_byp = 1'b0;
    logic              o_vld;
    logic              i_rdy = 1'b0;
    logic [7:0]        o_data_y;
    logic [7:0]        o_data_cb;
    logic [7:0]        o_data_cr;
    logic              o_busy;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_out   = 0;
    int          cyc     = 0;
    int          last_hs = -1;
    bit          chk_gap = 1'b0;
    logic [23:0] sb_q[$];

    ip_rgb2yuv_seq #(.DAT_SZ(DAT_SZ), .ACC_SZ(ACC_SZ)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_vld     (i_vld),
        .o_rdy     (o_rdy),
        .i_data_r  (i_data_r),
        .i_data_g  (i_data_g),
        .i_data_b  (i_data_b),
`ifdef IP_RGB2YUV_BYPASS_EN
        .i_byp     (tb_byp),
`endif
        .o_vld     (o_vld),
        .i_rdy     (i_rdy),
        .o_data_y  (o_data_y),
        .o_data_cb (o_data_cb),
        .o_data_cr (o_data_cr),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model, written directly from the conversion formula.
    function automatic logic [7:0] mac8(input int kr, input int kg, input int kb,
                                        input int r, input int g, input int b,
                                        input int ofs);
        int s;
        s = kr * r + kg * g + kb * b;
        s = (s + (1 << (DAT_SZ - 1))) >>> DAT_SZ;
        s = s + ofs;
        if (s < 0)   return 8'h00;
        if (s > 255) return 8'hFF;
        return s[7:0];
    endfunction

    function automatic logic [23:0] model(input logic [DAT_SZ-1:0] r,
                                          input logic [DAT_SZ-1:0] g,
                                          input logic [DAT_SZ-1:0] b,
                                          input logic byp);
        if (byp) return {r[DAT_SZ-1 -: 8], g[DAT_SZ-1 -: 8], b[DAT_SZ-1 -: 8]};
        return {mac8(77, 150, 29, int'(r), int'(g), int'(b), 0),
                mac8(-43, -84, 127, int'(r), int'(g), int'(b), 128),
                mac8(127, -106, -21, int'(r), int'(g), int'(b), 128)};
    endfunction

    // Scoreboard monitor: inputs are driven 1 time unit after posedge, so the
    // negedge sees exactly what the next posedge will sample.
    always @(negedge clk) begin
        logic [23:0] exp_v;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (o_vld && i_rdy) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_v = sb_q.pop_front();
                    chk("out_y",  {24'd0, o_data_y},  {24'd0, exp_v[23:16]});
                    chk("out_cb", {24'd0, o_data_cb}, {24'd0, exp_v[15:8]});
                    chk("out_cr", {24'd0, o_data_cr}, {24'd0, exp_v[7:0]});
                end
                if (chk_gap && last_hs >= 0) chk("hs_gap", cyc - last_hs, 32'd4);
                last_hs = cyc;
                n_out++;
            end
            if (i_vld && o_rdy) sb_q.push_back(model(i_data_r, i_data_g, i_data_b, tb_byp));
        end
    end

    // Present a pixel and hold it until the negedge before the accepting edge.
    task automatic send(input logic [DAT_SZ-1:0] r, input logic [DAT_SZ-1:0] g,
                        input logic [DAT_SZ-1:0] b, input logic byp);
        bit ok;
        @(posedge clk); #1;
        i_vld = 1'b1; i_data_r = r; i_data_g = g; i_data_b = b; tb_byp = byp;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_rdy) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic single(input logic [DAT_SZ-1:0] r, input logic [DAT_SZ-1:0] g,
                          input logic [DAT_SZ-1:0] b, input logic byp,
                          input logic [23:0] exp_c);
        int lat;
        send(r, g, b, byp);
        @(posedge clk); #1;
        i_vld = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) chk("busy_run", {31'd0, o_busy}, 32'd1);
            if (o_vld) begin lat = i; break; end
        end
        chk("latency", lat, 32'd4);
        chk("const_yuv", {8'd0, o_data_y, o_data_cb, o_data_cr}, {8'd0, exp_c});
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !o_vld) break;
        end
        chk("drain", sb_q.size(), 32'd0);
    endtask

    initial begin
        logic [23:0] exp_a;
        int          n0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",  {31'd0, o_vld}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_data", {8'd0, o_data_y, o_data_cb, o_data_cr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        i_rdy = 1'b1;
        @(negedge clk);
        chk("rst_rdy", {31'd0, o_rdy}, 32'd1);

        // Directed conversions with known results
        single(10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 24'hFF8080);
        single(10'h000, 10'h000, 10'h000, 1'b0, 24'h008080);
        single(10'h3FC, 10'h000, 10'h000, 1'b0, 24'h4D55FF);
        single(10'h000, 10'h000, 10'h3FC, 1'b0, 24'h1DFF6B);
`ifdef IP_RGB2YUV_BYPASS_EN
        single(10'h3FC, 10'h200, 10'h004, 1'b1, 24'hFF8001);
`endif
        drain();

        // Back-to-back stream of 8 pixels, handshakes every 4 cycles
        chk_gap = 1'b1;
        last_hs = -1;
        n0 = n_out;
        for (int p = 0; p < 8; p++) begin
            send(DAT_SZ'($urandom_range(0, 1023)), DAT_SZ'($urandom_range(0, 1023)),
                 DAT_SZ'($urandom_range(0, 1023)), 1'b0);
        end
        @(posedge clk); #1;
        i_vld = 1'b0;
        drain();
        chk("stream_cnt", n_out - n0, 32'd8);
        chk_gap = 1'b0;

        // Downstream stall in S_OUT while the next pixel waits upstream
        i_rdy = 1'b0;
        n0 = n_out;
        exp_a = model(10'h155, 10'h2AA, 10'h0F0, 1'b0);
        send(10'h155, 10'h2AA, 10'h0F0, 1'b0);
        @(posedge clk); #1;
        i_data_r = 10'h3C3; i_data_g = 10'h011; i_data_b = 10'h2F7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_vld) break;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_vld", {31'd0, o_vld}, 32'd1);
            chk("stall_rdy", {31'd0, o_rdy}, 32'd0);
            chk("stall_data", {8'd0, o_data_y, o_data_cb, o_data_cr}, {8'd0, exp_a});
        end
        @(posedge clk); #1;
        i_rdy = 1'b1;
        @(posedge clk); #1;
        i_vld = 1'b0;
        drain();
        chk("stall_cnt", n_out - n0, 32'd2);

        // Reset while in S_CB discards the in-flight pixel
        send(10'h0AB, 10'h1CD, 10'h3EF, 1'b0);
        @(posedge clk); #1;
        i_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_vld",  {31'd0, o_vld}, 32'd0);
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_rdy",  {31'd0, o_rdy}, 32'd1);
        chk("abort_data", {8'd0, o_data_y, o_data_cb, o_data_cr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n0 = n_out;
        repeat (10) @(negedge clk);
        chk("abort_no_out", n_out - n0, 32'd0);

        // Conversion still correct after abort
        single(10'h200, 10'h100, 10'h300, 1'b0, model(10'h200, 10'h100, 10'h300, 1'b0));
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
